text_write_ctrl: RTL and testbench
==================================

Name: text_write_ctrl

Overview:
Pixel-domain consumer of the IO write-decode stage. Takes the synchronised register strobes (we_0 = cursor set, we_1 = character write) plus the latched data word, and drives a text-mode VRAM write port. It maintains the row/column cursor, auto-advances with wrap, interprets control codes CR/LF/FF, and runs a multi-cycle clear-screen sequencer.

Parameters:
DATA_WIDTH, 16, width of io_din / vram_dout (high byte attribute, low byte character)
COLS, 80, text columns
ROWS, 30, text rows
ADDR_WIDTH, 12, VRAM address width (must hold COLS*ROWS-1)
BLANK_WORD, 16'h0020, word written to every cell by clear-screen

Ports:
clk  input  1  pixel clock (px_clk in system); only clock
rst  input  1  synchronous active-high reset
io_din  input  DATA_WIDTH  data word from write-decode stage, valid while we_0/we_1 high
we_0  input  1  one-cycle strobe: set cursor, row = io_din[15:8], col = io_din[7:0]
we_1  input  1  one-cycle strobe: character/control write
vram_we  output  1  VRAM write enable, one cycle per write
vram_addr  output  ADDR_WIDTH  VRAM linear address
vram_dout  output  DATA_WIDTH  VRAM write data
cursor_row  output  8  current row
cursor_col  output  8  current column
busy  output  1  high while clear-screen runs
drop_err  output  1  sticky: a strobe was discarded

Behaviour:
- Interface decided: one clock clk; rst synchronous, active-high.
- Reset: vram_we=0, vram_addr=0, vram_dout=0, cursor 0/0, busy=0, drop_err=0, FSM=IDLE. Reset mid-clear aborts immediately; no further VRAM writes.
- Internal linear cursor address cur_addr = row*COLS+col, kept incrementally (no divider); on cursor set computed by constant multiply-add, registered.
- All outputs registered; VRAM write appears the cycle after the strobe (latency 1).
- FSM states: IDLE, CLEAR.
- IDLE, we_0: if row<ROWS and col<COLS load them, else load 0/0. No VRAM write.
- IDLE, we_1, control code (io_din[15:8]==0):
  - 8'h0A LF: col=0, row=row+1, wrap ROWS-1 -> 0. No write.
  - 8'h0D CR: col=0. No write.
  - 8'h0C FF: enter CLEAR, busy=1 from next cycle.
- IDLE, we_1, any other word: vram_we=1, vram_addr=cur_addr, vram_dout=io_din next cycle; then advance col; col==COLS-1 -> col 0, row+1; row==ROWS-1 at end of row -> wrap to 0/0.
- CLEAR: writes BLANK_WORD to addresses 0..COLS*ROWS-1, one per cycle, consecutive cycles. After the last write: cursor 0/0, busy=0, return to IDLE. Total busy = COLS*ROWS cycles.
- we_0 and we_1 in the same cycle: we_0 processed, we_1 discarded, drop_err=1.
- Any strobe while busy: discarded, drop_err=1.
- drop_err cleared only by rst.
- Cursor outputs always reflect the post-update values, one cycle after the strobe.

Decomposition:
- Shared package text_pkg: COLS, ROWS, ADDR_WIDTH, BLANK_WORD, control-code constants CC_LF=8'h0A, CC_CR=8'h0D, CC_FF=8'h0C, FSM state encoding.
- One natural sub-module: text_cursor (row/col/linear-address counters with set, advance, newline, CR, and wrap). The top holds the FSM, clear counter and VRAM output registers.

Test Plan:
- Reset, then we_1 io_din=16'h0741 -> next cycle vram_we=1, addr=0, dout=16'h0741; cursor 0/1.
- we_0 16'h0203, then we_1 16'h0042 -> write at addr 163; cursor 2/4.
- we_0 16'h1D4F (row 29, col 79), then we_1 16'h0058 -> write at addr 2399; cursor wraps to 0/0.
- we_0 16'h0505, then LF -> cursor 6/0, no vram_we. CR from 6/7 -> 6/0. we_0 16'h2000 (row 32, out of range) -> 0/0.
- FF -> busy for exactly 2400 cycles, addresses 0..2399 written with 16'h0020; we_1 during busy -> no write, drop_err=1. Cursor 0/0 after.
- rst asserted at clear cycle 100 -> vram_we=0 next cycle, busy=0. Simultaneous we_0+we_1 -> only cursor set, drop_err=1.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants, control codes and FSM encoding for the text-mode VRAM writer.
package text_pkg;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned COLS       = 80;
  localparam int unsigned ROWS       = 30;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned CELLS      = COLS * ROWS;

  localparam logic [DATA_WIDTH-1:0] BLANK_WORD = 16'h0020;

  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_FF = 8'h0C;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/text_write_ctrl_if.sv
// Strobe/data input from the write-decode stage and the VRAM write port.
interface text_write_ctrl_if
  import text_pkg::*;
();
  logic [DATA_WIDTH-1:0] io_din;
  logic                  we_0;
  logic                  we_1;
  logic                  vram_we;
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [DATA_WIDTH-1:0] vram_dout;

  modport master (output io_din, we_0, we_1, input vram_we, vram_addr, vram_dout);
  modport slave  (input io_din, we_0, we_1, output vram_we, vram_addr, vram_dout);
endinterface

// File: rtl/text_cursor.sv
// Row/column cursor with an incrementally maintained linear address (row*COLS+col).
module text_cursor
  import text_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  home,
  input  logic                  set,
  input  logic [7:0]            set_row,
  input  logic [7:0]            set_col,
  input  logic                  adv,
  input  logic                  newline,
  input  logic                  cr,
  output logic [7:0]            row,
  output logic [7:0]            col,
  output logic [ADDR_WIDTH-1:0] addr
);
  localparam logic [7:0]            LAST_COL = 8'(COLS - 1);
  localparam logic [7:0]            LAST_ROW = 8'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] COLS_A   = ADDR_WIDTH'(COLS);

  logic [7:0]            row_q, row_d;
  logic [7:0]            col_q, col_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (home) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (set) begin
      // Out-of-range coordinates fall back to home
      if (set_row <= LAST_ROW && set_col <= LAST_COL) begin
        row_d  = set_row;
        col_d  = set_col;
        addr_d = ADDR_WIDTH'(set_row) * COLS_A + ADDR_WIDTH'(set_col);
      end else begin
        row_d  = '0;
        col_d  = '0;
        addr_d = '0;
      end
    end else if (adv) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        if (row_q == LAST_ROW) begin
          row_d  = '0;
          addr_d = '0;
        end else begin
          row_d  = row_q + 8'd1;
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end else begin
        col_d  = col_q + 8'd1;
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end else if (newline) begin
      col_d = '0;
      if (row_q == LAST_ROW) begin
        row_d  = '0;
        addr_d = '0;
      end else begin
        row_d  = row_q + 8'd1;
        addr_d = addr_q - ADDR_WIDTH'(col_q) + COLS_A;
      end
    end else if (cr) begin
      col_d  = '0;
      addr_d = addr_q - ADDR_WIDTH'(col_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign addr = addr_q;
endmodule

// File: rtl/text_write_ctrl.sv
// Text-mode VRAM write controller: character writes, control codes and clear-screen sequencer.
module text_write_ctrl
  import text_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  text_write_ctrl_if.slave   bus,
  output logic [7:0]         cursor_row,
  output logic [7:0]         cursor_col,
  output logic               busy,
  output logic               drop_err
);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(CELLS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  vram_we_q, vram_we_d;
  logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_WIDTH-1:0] vram_dout_q, vram_dout_d;
  logic                  busy_q, busy_d;
  logic                  drop_err_q, drop_err_d;

  logic                  cur_home_c, cur_set_c, cur_adv_c, cur_nl_c, cur_cr_c;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  is_ctrl_c;

  text_cursor u_cursor (
    .clk     (clk),
    .rst     (rst),
    .home    (cur_home_c),
    .set     (cur_set_c),
    .set_row (bus.io_din[15:8]),
    .set_col (bus.io_din[7:0]),
    .adv     (cur_adv_c),
    .newline (cur_nl_c),
    .cr      (cur_cr_c),
    .row     (cursor_row),
    .col     (cursor_col),
    .addr    (cur_addr)
  );

  assign is_ctrl_c = (bus.io_din[15:8] == 8'h00);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    vram_we_d   = 1'b0;
    vram_addr_d = vram_addr_q;
    vram_dout_d = vram_dout_q;
    busy_d      = busy_q;
    drop_err_d  = drop_err_q;
    cur_home_c  = 1'b0;
    cur_set_c   = 1'b0;
    cur_adv_c   = 1'b0;
    cur_nl_c    = 1'b0;
    cur_cr_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Cursor set wins over a coincident character write
        if (bus.we_0) begin
          cur_set_c = 1'b1;
          if (bus.we_1) drop_err_d = 1'b1;
        end else if (bus.we_1) begin
          if (is_ctrl_c && bus.io_din[7:0] == CC_LF) begin
            cur_nl_c = 1'b1;
          end else if (is_ctrl_c && bus.io_din[7:0] == CC_CR) begin
            cur_cr_c = 1'b1;
          end else if (is_ctrl_c && bus.io_din[7:0] == CC_FF) begin
            state_d   = ST_CLEAR;
            busy_d    = 1'b1;
            clr_cnt_d = '0;
          end else begin
            vram_we_d   = 1'b1;
            vram_addr_d = cur_addr;
            vram_dout_d = bus.io_din;
            cur_adv_c   = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (bus.we_0 || bus.we_1) drop_err_d = 1'b1;
        vram_we_d   = 1'b1;
        vram_addr_d = clr_cnt_q;
        vram_dout_d = BLANK_WORD;
        if (clr_cnt_q == LAST_CELL) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          clr_cnt_d  = '0;
          cur_home_c = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_dout_q <= '0;
      busy_q      <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_dout_q <= vram_dout_d;
      busy_q      <= busy_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign bus.vram_we   = vram_we_q;
  assign bus.vram_addr = vram_addr_q;
  assign bus.vram_dout = vram_dout_q;
  assign busy          = busy_q;
  assign drop_err      = drop_err_q;
endmodule

// File: tb/tb_text_write_ctrl.sv
// Bench for text_write_ctrl: directed vector table, clear/reset sequences, randomized model check.
module tb_text_write_ctrl;
  import text_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  text_write_ctrl_if bus_if ();
  logic [7:0] cursor_row, cursor_col;
  logic       busy, drop_err;

  text_write_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy),
    .drop_err   (drop_err)
  );

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [15:0] dout;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        busy;
    logic        drop;
  } obs_t;

  typedef struct {
    logic        we0;
    logic        we1;
    logic [15:0] din;
    obs_t        exp;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cursor as row/col, clear as a count of cells still to blank
  int          m_row, m_col, m_left, m_addr;
  logic        m_drop, m_we;
  logic [15:0] m_dout;

  function automatic obs_t mk(input logic we, input int addr, input logic [15:0] dout,
                              input int row, input int col, input logic b, input logic d);
    obs_t o;
    o.we = we; o.addr = 12'(addr); o.dout = dout;
    o.row = 8'(row); o.col = 8'(col); o.busy = b; o.drop = d;
    return o;
  endfunction

  function automatic obs_t model_obs();
    return mk(m_we, m_addr, m_dout, m_row, m_col, m_left > 0, m_drop);
  endfunction

  task automatic ref_reset();
    m_row = 0; m_col = 0; m_left = 0; m_addr = 0;
    m_drop = 1'b0; m_we = 1'b0; m_dout = '0;
  endtask

  task automatic ref_step(input logic w0, input logic w1, input logic [15:0] d);
    int r, c, idx;
    m_we = 1'b0;
    if (m_left > 0) begin
      if (w0 || w1) m_drop = 1'b1;
      m_we = 1'b1;
      m_addr = int'(CELLS) - m_left;
      m_dout = BLANK_WORD;
      m_left--;
      if (m_left == 0) begin m_row = 0; m_col = 0; end
    end else if (w0) begin
      if (w1) m_drop = 1'b1;
      r = int'(d[15:8]); c = int'(d[7:0]);
      if (r < int'(ROWS) && c < int'(COLS)) begin m_row = r; m_col = c; end
      else begin m_row = 0; m_col = 0; end
    end else if (w1) begin
      if (d == {8'h00, CC_LF}) begin
        m_row = (m_row + 1) % int'(ROWS); m_col = 0;
      end else if (d == {8'h00, CC_CR}) begin
        m_col = 0;
      end else if (d == {8'h00, CC_FF}) begin
        m_left = int'(CELLS);
      end else begin
        m_we = 1'b1;
        m_addr = m_row * int'(COLS) + m_col;
        m_dout = d;
        idx = (m_addr + 1) % int'(CELLS);
        m_row = idx / int'(COLS);
        m_col = idx % int'(COLS);
      end
    end
  endtask

  task automatic compare(input string name, input obs_t exp);
    obs_t act;
    act = mk(bus_if.vram_we, int'(bus_if.vram_addr), bus_if.vram_dout,
             int'(cursor_row), int'(cursor_col), busy, drop_err);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got we=%0d addr=%0d dout=%h row=%0d col=%0d busy=%0d drop=%0d, expected we=%0d addr=%0d dout=%h row=%0d col=%0d busy=%0d drop=%0d",
               name, act.we, act.addr, act.dout, act.row, act.col, act.busy, act.drop,
               exp.we, exp.addr, exp.dout, exp.row, exp.col, exp.busy, exp.drop);
    end
  endtask

  task automatic drive(input logic w0, input logic w1, input logic [15:0] d);
    bus_if.we_0 = w0; bus_if.we_1 = w1; bus_if.io_din = d;
    @(posedge clk); #1;
    bus_if.we_0 = 1'b0; bus_if.we_1 = 1'b0; bus_if.io_din = $urandom();
    ref_step(w0, w1, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_reset();
    compare("reset", mk(1'b0, 0, 16'h0000, 0, 0, 1'b0, 1'b0));
  endtask

  vec_t tbl[12];

  initial begin
    int ff_budget;
    int sel;
    logic w0, w1;
    logic [15:0] d;

    rst = 1'b1;
    bus_if.we_0 = 1'b0; bus_if.we_1 = 1'b0; bus_if.io_din = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    tbl[0]  = '{1'b0, 1'b1, 16'h0741, mk(1'b1,    0, 16'h0741,  0,  1, 1'b0, 1'b0)};
    tbl[1]  = '{1'b1, 1'b0, 16'h0203, mk(1'b0,    0, 16'h0741,  2,  3, 1'b0, 1'b0)};
    tbl[2]  = '{1'b0, 1'b1, 16'h0042, mk(1'b1,  163, 16'h0042,  2,  4, 1'b0, 1'b0)};
    tbl[3]  = '{1'b1, 1'b0, 16'h1D4F, mk(1'b0,  163, 16'h0042, 29, 79, 1'b0, 1'b0)};
    tbl[4]  = '{1'b0, 1'b1, 16'h0058, mk(1'b1, 2399, 16'h0058,  0,  0, 1'b0, 1'b0)};
    tbl[5]  = '{1'b1, 1'b0, 16'h0505, mk(1'b0, 2399, 16'h0058,  5,  5, 1'b0, 1'b0)};
    tbl[6]  = '{1'b0, 1'b1, 16'h000A, mk(1'b0, 2399, 16'h0058,  6,  0, 1'b0, 1'b0)};
    tbl[7]  = '{1'b1, 1'b0, 16'h0607, mk(1'b0, 2399, 16'h0058,  6,  7, 1'b0, 1'b0)};
    tbl[8]  = '{1'b0, 1'b1, 16'h000D, mk(1'b0, 2399, 16'h0058,  6,  0, 1'b0, 1'b0)};
    tbl[9]  = '{1'b1, 1'b0, 16'h2000, mk(1'b0, 2399, 16'h0058,  0,  0, 1'b0, 1'b0)};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, mk(1'b0, 2399, 16'h0058,  0,  0, 1'b0, 1'b0)};
    tbl[11] = '{1'b1, 1'b1, 16'h0304, mk(1'b0, 2399, 16'h0058,  3,  4, 1'b0, 1'b1)};

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].we0, tbl[i].we1, tbl[i].din);
      compare($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Full clear-screen with a character strobe dropped mid-way
    do_reset();
    drive(1'b1, 1'b0, 16'h0A0A);
    compare("pre_ff_cursor", mk(1'b0, 0, 16'h0000, 10, 10, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 16'h000C);
    compare("ff_busy", mk(1'b0, 0, 16'h0000, 10, 10, 1'b1, 1'b0));
    for (int k = 0; k < int'(CELLS); k++) begin
      drive(1'b0, k == 50, 16'h0041);
      compare($sformatf("clear%0d", k),
              mk(1'b1, k, 16'h0020, (k == int'(CELLS) - 1) ? 0 : 10,
                 (k == int'(CELLS) - 1) ? 0 : 10, k < int'(CELLS) - 1, k >= 50));
    end
    drive(1'b0, 1'b0, 16'h0000);
    compare("post_clear", mk(1'b0, 2399, 16'h0020, 0, 0, 1'b0, 1'b1));

    // Reset during clear aborts the sequence
    do_reset();
    drive(1'b0, 1'b1, 16'h000C);
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 1'b0, 16'h0000);
      compare($sformatf("clr_pre_rst%0d", k), model_obs());
    end
    do_reset();
    drive(1'b0, 1'b0, 16'h0000);
    compare("after_rst_mid_clear", mk(1'b0, 0, 16'h0000, 0, 0, 1'b0, 1'b0));

    // Randomized traffic against the reference model
    do_reset();
    ff_budget = 2;
    for (int n = 0; n < 4000; n++) begin
      sel = int'($urandom_range(0, 99));
      w0 = (sel < 15);
      w1 = (sel >= 10 && sel < 80);
      sel = int'($urandom_range(0, 99));
      if (sel < 12)      d = {8'h00, CC_LF};
      else if (sel < 22) d = {8'h00, CC_CR};
      else if (sel < 24 && ff_budget > 0 && w1 && !w0 && m_left == 0) begin
        d = {8'h00, CC_FF};
        ff_budget--;
      end
      else if (sel < 50) d = {8'($urandom_range(0, 34)), 8'($urandom_range(0, 85))};
      else               d = 16'($urandom());
      if (d == {8'h00, CC_FF} && !(w1 && !w0 && m_left == 0)) d = 16'h0141;
      drive(w0, w1, d);
      compare($sformatf("rand%0d", n), model_obs());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
